// File: rtl/arm_pkg.sv
// Shared ARM load/store-multiple definitions: addressing modes, FSM states, widths.
package arm_pkg;

   localparam int unsigned WORD_BYTES = 4;
   localparam int unsigned REG_PC     = 15;
   localparam int unsigned NREGS      = 16;
   localparam int unsigned REG_W      = 4;
   localparam int unsigned CNT_W      = 5;

   // Encoded as {p_bit, u_bit}
   typedef enum logic [1:0] {
      AM_DA = 2'b00,
      AM_IA = 2'b01,
      AM_DB = 2'b10,
      AM_IB = 2'b11
   } addr_mode_e;

   typedef enum logic [2:0] {
      S_IDLE,
      S_XFER,
      S_DRAIN,
      S_WB,
      S_DONE
   } seq_state_e;

   function automatic addr_mode_e decode_mode(input logic p, input logic u);
      return addr_mode_e'({p, u});
   endfunction

endpackage

// File: rtl/ldm_stm_sequencer_if.sv
// Request, register-file and memory ports of the LDM/STM sequencer.
interface ldm_stm_sequencer_if #(parameter int unsigned XLEN = 32);

   logic            start;
   logic            is_load;
   logic            p_bit;
   logic            u_bit;
   logic            w_bit;
   logic [15:0]     reglist;
   logic [3:0]      base_reg;
   logic [XLEN-1:0] base_val;

   logic [3:0]      rf_ra;
   logic [XLEN-1:0] rf_rd;
   logic            rf_we;
   logic [3:0]      rf_wa;
   logic [XLEN-1:0] rf_wd;

   logic [XLEN-1:0] mem_addr;
   logic            mem_we;
   logic            mem_re;
   logic [XLEN-1:0] mem_wd;
   logic [XLEN-1:0] mem_rdata;

   logic            busy;
   logic            done;
   logic            pc_loaded;

   modport master (
      output start, is_load, p_bit, u_bit, w_bit, reglist, base_reg, base_val,
      output rf_rd, mem_rdata,
      input  rf_ra, rf_we, rf_wa, rf_wd, mem_addr, mem_we, mem_re, mem_wd,
      input  busy, done, pc_loaded
   );

   modport slave (
      input  start, is_load, p_bit, u_bit, w_bit, reglist, base_reg, base_val,
      input  rf_rd, mem_rdata,
      output rf_ra, rf_we, rf_wa, rf_wd, mem_addr, mem_we, mem_re, mem_wd,
      output busy, done, pc_loaded
   );

endinterface

// File: rtl/reglist_scan.sv
// Combinational population count and lowest-set-bit index of a 16-bit register mask.
module reglist_scan
   import arm_pkg::*;
(
   input  logic [NREGS-1:0] mask_i,
   output logic [CNT_W-1:0] count_o,
   output logic [REG_W-1:0] low_idx_o
);

   // Descending walk so the last hit is the lowest set bit
   always_comb begin
      count_o   = '0;
      low_idx_o = '0;
      for (int i = int'(NREGS) - 1; i >= 0; i--) begin
         count_o = count_o + CNT_W'(mask_i[i]);
         if (mask_i[i]) low_idx_o = REG_W'(i);
      end
   end

endmodule

// File: rtl/ldm_stm_sequencer.sv
// ARM LDM/STM sequencer: one register per cycle, loads written back one cycle after issue,
// optional base writeback at the end.
module ldm_stm_sequencer
   import arm_pkg::*;
#(
   parameter int unsigned XLEN = 32
) (
   input logic               clk,
   input logic               rst,
   ldm_stm_sequencer_if.slave bus
);

   seq_state_e       state_q, state_d;
   logic             load_q, load_d, w_q, w_d, u_q, u_d;
   logic [REG_W-1:0] base_reg_q, base_reg_d, cur_reg_q, cur_reg_d;
   logic [XLEN-1:0]  base_val_q, base_val_d;
   logic [NREGS-1:0] list_q, list_d, mask_q, mask_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic [REG_W-1:0] rf_ra_q, rf_ra_d, rf_wa_q, rf_wa_d;
   logic             rf_we_q, rf_we_d, ld_wr_q, ld_wr_d;
   logic [XLEN-1:0]  wd_q, wd_d, mem_addr_q, mem_addr_d;
   logic             mem_we_q, mem_we_d, mem_re_q, mem_re_d;
   logic             busy_q, busy_d, done_q, done_d, pc_q, pc_d;

   logic [NREGS-1:0] scan_in;
   logic [CNT_W-1:0] scan_cnt;
   logic [REG_W-1:0] scan_low;
   logic [XLEN-1:0]  start_span, start_addr, span, wb_value;
   logic             wb_en;
   logic             issue;
   logic [XLEN-1:0]  issue_addr;

   // At start the scanner sees the incoming list, afterwards the remaining mask
   assign scan_in = (state_q == S_IDLE) ? bus.reglist : mask_q;

   reglist_scan u_scan (
      .mask_i    (scan_in),
      .count_o   (scan_cnt),
      .low_idx_o (scan_low)
   );

   assign start_span = XLEN'(scan_cnt) * XLEN'(WORD_BYTES);

   always_comb begin
      unique case (decode_mode(bus.p_bit, bus.u_bit))
         AM_IA:   start_addr = bus.base_val;
         AM_IB:   start_addr = bus.base_val + XLEN'(WORD_BYTES);
         AM_DA:   start_addr = bus.base_val - start_span + XLEN'(WORD_BYTES);
         default: start_addr = bus.base_val - start_span;
      endcase
   end

   assign span     = XLEN'(cnt_q) * XLEN'(WORD_BYTES);
   assign wb_value = u_q ? (base_val_q + span) : (base_val_q - span);
   // A loaded base register wins over writeback; empty lists never write back
   assign wb_en    = w_q && (cnt_q != '0) && !(load_q && list_q[base_reg_q]);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         load_q     <= 1'b0;
         w_q        <= 1'b0;
         u_q        <= 1'b0;
         base_reg_q <= '0;
         cur_reg_q  <= '0;
         base_val_q <= '0;
         list_q     <= '0;
         mask_q     <= '0;
         cnt_q      <= '0;
         rf_ra_q    <= '0;
         rf_wa_q    <= '0;
         rf_we_q    <= 1'b0;
         ld_wr_q    <= 1'b0;
         wd_q       <= '0;
         mem_addr_q <= '0;
         mem_we_q   <= 1'b0;
         mem_re_q   <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         pc_q       <= 1'b0;
      end else begin
         state_q    <= state_d;
         load_q     <= load_d;
         w_q        <= w_d;
         u_q        <= u_d;
         base_reg_q <= base_reg_d;
         cur_reg_q  <= cur_reg_d;
         base_val_q <= base_val_d;
         list_q     <= list_d;
         mask_q     <= mask_d;
         cnt_q      <= cnt_d;
         rf_ra_q    <= rf_ra_d;
         rf_wa_q    <= rf_wa_d;
         rf_we_q    <= rf_we_d;
         ld_wr_q    <= ld_wr_d;
         wd_q       <= wd_d;
         mem_addr_q <= mem_addr_d;
         mem_we_q   <= mem_we_d;
         mem_re_q   <= mem_re_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         pc_q       <= pc_d;
      end
   end

   // Next state plus the strobes that will be presented during the next cycle
   always_comb begin
      state_d    = state_q;
      load_d     = load_q;
      w_d        = w_q;
      u_d        = u_q;
      base_reg_d = base_reg_q;
      cur_reg_d  = cur_reg_q;
      base_val_d = base_val_q;
      list_d     = list_q;
      mask_d     = mask_q;
      cnt_d      = cnt_q;
      rf_ra_d    = '0;
      rf_wa_d    = '0;
      rf_we_d    = 1'b0;
      ld_wr_d    = 1'b0;
      wd_d       = '0;
      mem_addr_d = '0;
      mem_we_d   = 1'b0;
      mem_re_d   = 1'b0;
      issue      = 1'b0;
      issue_addr = '0;

      unique case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               load_d     = bus.is_load;
               w_d        = bus.w_bit;
               u_d        = bus.u_bit;
               base_reg_d = bus.base_reg;
               base_val_d = bus.base_val;
               list_d     = bus.reglist;
               mask_d     = bus.reglist;
               cnt_d      = scan_cnt;
               if (scan_cnt != '0) begin
                  state_d    = S_XFER;
                  issue      = 1'b1;
                  issue_addr = start_addr;
               end else begin
                  // Empty list spends one idle cycle in DRAIN before DONE
                  state_d = S_DRAIN;
               end
            end
         end
         S_XFER: begin
            if (load_q) begin
               rf_we_d = 1'b1;
               rf_wa_d = cur_reg_q;
               ld_wr_d = 1'b1;
            end
            if (mask_q != '0) begin
               issue      = 1'b1;
               issue_addr = mem_addr_q + XLEN'(WORD_BYTES);
            end else if (load_q) begin
               state_d = S_DRAIN;
            end else begin
               state_d = wb_en ? S_WB : S_DONE;
            end
         end
         S_DRAIN: state_d = wb_en ? S_WB : S_DONE;
         S_WB:    state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      if (issue) begin
         mem_addr_d = issue_addr;
         mem_re_d   = load_d;
         mem_we_d   = !load_d;
         rf_ra_d    = load_d ? '0 : scan_low;
         cur_reg_d  = scan_low;
         mask_d     = scan_in & ~(NREGS'(1) << scan_low);
      end

      if ((state_d == S_WB) && (state_q != S_WB)) begin
         rf_we_d = 1'b1;
         rf_wa_d = base_reg_q;
         wd_d    = wb_value;
      end
   end

   assign busy_d = (state_d != S_IDLE);
   assign done_d = (state_d == S_DONE);
   assign pc_d   = (state_d == S_DONE) && load_q && list_q[REG_PC];

   assign bus.rf_ra     = rf_ra_q;
   assign bus.rf_we     = rf_we_q;
   assign bus.rf_wa     = rf_wa_q;
   assign bus.rf_wd     = ld_wr_q ? bus.mem_rdata : wd_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_we    = mem_we_q;
   assign bus.mem_re    = mem_re_q;
   assign bus.mem_wd    = mem_we_q ? bus.rf_rd : '0;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.pc_loaded = pc_q;

endmodule

// File: tb/tb_ldm_stm_sequencer.sv
// Scoreboard bench for ldm_stm_sequencer: directed transfers push expected strobe events,
// a negedge monitor pops and compares every strobe the DUT presents.
module tb_ldm_stm_sequencer;

   localparam int K_MR = 0;
   localparam int K_MW = 1;
   localparam int K_RW = 2;
   localparam int K_DN = 3;

   typedef struct {
      int          k;
      logic [31:0] a;
      logic [31:0] d;
      int          c;
   } ev_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   ldm_stm_sequencer_if #(.XLEN(32)) bus ();

   ldm_stm_sequencer #(.XLEN(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   logic [31:0] rf  [16];
   logic [31:0] mem [logic [31:0]];
   ev_t         expq [$];
   int          n_chk  = 0;
   int          n_fail = 0;
   int          cyc    = 0;
   int          t0     = 0;
   string       kname [4] = '{"MR", "MW", "RW", "DN"};

   // Register file read is combinational; memory read data follows mem_re by one cycle
   assign bus.rf_rd = rf[bus.rf_ra];

   always @(posedge clk) begin
      cyc <= cyc + 1;
      bus.mem_rdata <= (bus.mem_re && mem.exists(bus.mem_addr)) ? mem[bus.mem_addr] : 32'h0;
   end

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
      n_chk++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", nm, got, want);
      end
   endtask

   function automatic void exp_ev(input int k, input logic [31:0] a, input logic [31:0] d,
                                  input int c);
      ev_t e;
      e.k = k; e.a = a; e.d = d; e.c = c;
      expq.push_back(e);
   endfunction

   task automatic check_ev(input int k, input logic [31:0] a, input logic [31:0] d);
      ev_t e;
      int  rel;
      rel = cyc - t0;
      n_chk++;
      if (expq.size() == 0) begin
         n_fail++;
         $display("FAIL unexpected %s: a=%h d=%h cycle %0d", kname[k], a, d, rel);
      end else begin
         e = expq.pop_front();
         if (e.k != k || e.a !== a || e.d !== d || e.c != rel) begin
            n_fail++;
            $display("FAIL event: got %s a=%h d=%h cycle %0d, expected %s a=%h d=%h cycle %0d",
                     kname[k], a, d, rel, kname[e.k], e.a, e.d, e.c);
         end
      end
   endtask

   // Monitor: fixed per-cycle order MR, MW, RW, DN
   always @(negedge clk) begin
      if (bus.mem_re) check_ev(K_MR, bus.mem_addr, 32'h0);
      if (bus.mem_we) begin
         check_ev(K_MW, bus.mem_addr, bus.mem_wd);
         chk("strobe_excl", {30'b0, bus.mem_re, bus.rf_we}, 32'h0);
      end
      if (bus.rf_we)  check_ev(K_RW, {28'b0, bus.rf_wa}, bus.rf_wd);
      if (bus.done)   check_ev(K_DN, 32'h0, {31'b0, bus.pc_loaded});
   end

   task automatic issue(input logic ld, input logic p, input logic u, input logic w,
                        input logic [15:0] rl, input logic [3:0] br, input logic [31:0] bv);
      @(negedge clk);
      bus.start = 1'b1; bus.is_load = ld; bus.p_bit = p; bus.u_bit = u; bus.w_bit = w;
      bus.reglist = rl; bus.base_reg = br; bus.base_val = bv;
      t0 = cyc;
      @(negedge clk);
      bus.start = 1'b0;
   endtask

   task automatic drain(input string nm);
      for (int i = 0; i < 40 && expq.size() > 0; i++) @(negedge clk);
      if (expq.size() > 0) begin
         n_chk++;
         n_fail++;
         $display("FAIL %s timeout: %0d events outstanding, expected 0", nm, expq.size());
         expq.delete();
      end
      repeat (2) @(negedge clk);
      chk({nm, "_idle_busy"}, {31'b0, bus.busy}, 32'h0);
   endtask

   initial begin
      bus.start = 1'b0; bus.is_load = 1'b0; bus.p_bit = 1'b0; bus.u_bit = 1'b0;
      bus.w_bit = 1'b0; bus.reglist = '0; bus.base_reg = '0; bus.base_val = '0;
      for (int i = 0; i < 16; i++) rf[i] = 32'h1000 + 32'(i);
      rf[1] = 32'h11; rf[2] = 32'h22; rf[3] = 32'h33; rf[4] = 32'h300;
      mem[32'h1F4] = 32'hA0; mem[32'h1F8] = 32'hA1; mem[32'h1FC] = 32'hA2;
      mem[32'h40]  = 32'hDEAD;
      mem[32'h604] = 32'hB1; mem[32'h608] = 32'hB2;

      // Reset state, with start held during reset to show reset wins
      repeat (2) @(negedge clk);
      bus.start = 1'b1; bus.reglist = 16'h00FF;
      @(negedge clk);
      bus.start = 1'b0; bus.reglist = '0;
      chk("rst_busy",     {31'b0, bus.busy},      32'h0);
      chk("rst_done",     {31'b0, bus.done},      32'h0);
      chk("rst_pc",       {31'b0, bus.pc_loaded}, 32'h0);
      chk("rst_strobes",  {29'b0, bus.mem_we, bus.mem_re, bus.rf_we}, 32'h0);
      chk("rst_mem_addr", bus.mem_addr,           32'h0);
      chk("rst_ra_wa",    {24'b0, bus.rf_ra, bus.rf_wa}, 32'h0);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_start_ignored", {31'b0, bus.busy}, 32'h0);

      // STM IA, writeback
      exp_ev(K_MW, 32'h100, 32'h11, 1);
      exp_ev(K_MW, 32'h104, 32'h22, 2);
      exp_ev(K_MW, 32'h108, 32'h33, 3);
      exp_ev(K_RW, 32'd13, 32'h10C, 4);
      exp_ev(K_DN, 32'h0, 32'h0, 5);
      issue(1'b0, 1'b0, 1'b1, 1'b1, 16'h000E, 4'd13, 32'h100);
      drain("stm_ia");

      // LDM DB including PC, no writeback
      exp_ev(K_MR, 32'h1F4, 32'h0, 1);
      exp_ev(K_MR, 32'h1F8, 32'h0, 2);
      exp_ev(K_RW, 32'd0, 32'hA0, 2);
      exp_ev(K_MR, 32'h1FC, 32'h0, 3);
      exp_ev(K_RW, 32'd1, 32'hA1, 3);
      exp_ev(K_RW, 32'd15, 32'hA2, 4);
      exp_ev(K_DN, 32'h0, 32'h1, 5);
      issue(1'b1, 1'b1, 1'b0, 1'b0, 16'h8003, 4'd5, 32'h200);
      drain("ldm_db");

      // LDM IA with base in list: loaded value wins, no writeback
      exp_ev(K_MR, 32'h40, 32'h0, 1);
      exp_ev(K_RW, 32'd2, 32'hDEAD, 2);
      exp_ev(K_DN, 32'h0, 32'h0, 3);
      issue(1'b1, 1'b0, 1'b1, 1'b1, 16'h0004, 4'd2, 32'h40);
      drain("ldm_base_in_list");

      // Empty list
      exp_ev(K_DN, 32'h0, 32'h0, 2);
      issue(1'b1, 1'b1, 1'b1, 1'b1, 16'h0000, 4'd3, 32'h80);
      drain("empty");

      // STM DA wrapping below zero, decrementing writeback
      exp_ev(K_MW, 32'hFFFF_FFFC, 32'h1000, 1);
      exp_ev(K_MW, 32'h0000_0000, 32'h11, 2);
      exp_ev(K_RW, 32'd9, 32'hFFFF_FFF8, 3);
      exp_ev(K_DN, 32'h0, 32'h0, 4);
      issue(1'b0, 1'b0, 1'b0, 1'b1, 16'h0003, 4'd9, 32'h0);
      drain("stm_da_wrap");

      // STM IB with base in list stores the original base
      exp_ev(K_MW, 32'h304, 32'h300, 1);
      exp_ev(K_MW, 32'h308, 32'h1005, 2);
      exp_ev(K_RW, 32'd4, 32'h308, 3);
      exp_ev(K_DN, 32'h0, 32'h0, 4);
      issue(1'b0, 1'b1, 1'b1, 1'b1, 16'h0030, 4'd4, 32'h300);
      drain("stm_ib_base");

      // LDM IB with writeback: n+3 latency
      exp_ev(K_MR, 32'h604, 32'h0, 1);
      exp_ev(K_MR, 32'h608, 32'h0, 2);
      exp_ev(K_RW, 32'd1, 32'hB1, 2);
      exp_ev(K_RW, 32'd2, 32'hB2, 3);
      exp_ev(K_RW, 32'd0, 32'h608, 4);
      exp_ev(K_DN, 32'h0, 32'h0, 5);
      issue(1'b1, 1'b1, 1'b1, 1'b1, 16'h0006, 4'd0, 32'h600);
      drain("ldm_ib_wb");

      // Abort a 4-register STM in its 2nd transfer cycle; a start while busy is ignored
      exp_ev(K_MW, 32'h500, 32'h1000, 1);
      exp_ev(K_MW, 32'h504, 32'h11, 2);
      issue(1'b0, 1'b0, 1'b1, 1'b1, 16'h000F, 4'd7, 32'h500);
      bus.start = 1'b1; bus.is_load = 1'b1; bus.reglist = 16'h00F0; bus.base_val = 32'h900;
      @(negedge clk);
      bus.start = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("abort_busy",   {31'b0, bus.busy},   32'h0);
      chk("abort_mem_we", {31'b0, bus.mem_we}, 32'h0);
      repeat (10) @(negedge clk);
      chk("abort_pending", 32'(expq.size()), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
